// File: rtl/traffic_checker.sv
// Receive-side traffic checker: compares a ready/valid payload stream against a
// seeded Galois LFSR sequence and reports counts, first failure, latency and span.
module traffic_checker #(
  parameter int          WIDTH_DATA = 400,
  parameter int          N_EXPECT   = 100,
  parameter logic [31:0] SEED       = 32'hBAADF00D,
  parameter logic [31:0] POLY       = 32'hA3000000,
  parameter int          CNT_W      = 32,
  parameter int          TIMEOUT    = 4096
) (
  input  logic                  clk_rtl,
  input  logic                  rst,
  input  logic [WIDTH_DATA-1:0] i_data_in,
  input  logic                  i_valid_in,
  output logic                  i_ready_out,
  input  logic                  i_start,
  input  logic                  i_stall,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [CNT_W-1:0]      o_num_rx,
  output logic [CNT_W-1:0]      o_num_fail,
  output logic [CNT_W-1:0]      o_first_fail,
  output logic [CNT_W-1:0]      o_latency,
  output logic [CNT_W-1:0]      o_span,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_EXPECT - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  state_t                state_q;
  state_t                state_d;
  logic [31:0]           lfsr_q;
  logic [31:0]           lfsr_next;
  logic [WIDTH_DATA-1:0] exp_beat;
  logic [CNT_W-1:0]      num_rx_q;
  logic [CNT_W-1:0]      num_fail_q;
  logic [CNT_W-1:0]      first_fail_q;
  logic [CNT_W-1:0]      latency_q;
  logic [CNT_W-1:0]      span_q;
  logic [CNT_W-1:0]      idle_q;
  logic                  timeout_q;

  logic accept;
  logic start_arm;
  logic mismatch;
  logic last_beat;
  logic idle_expire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  // Handshake: a beat transfers on any rising edge where i_valid_in and
  // i_ready_out are both high; ready never depends on valid, and the sender
  // must hold data stable while valid is high and ready is low.
  assign accept    = i_valid_in & i_ready_out;
  assign start_arm = i_start & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign mismatch  = (i_data_in != exp_beat);
  assign last_beat = (num_rx_q == LAST_IDX);
  assign idle_expire = (state_q == S_RUN) & ~accept & (idle_q == IDLE_LAST);

  // Expected payload is the 32-bit LFSR word repeated across the beat.
  always_comb begin
    exp_beat = '0;
    for (int i = 0; i < WIDTH_DATA; i++) begin
      exp_beat[i] = lfsr_q[i % 32];
    end
  end

  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);

  // FSM: state register
  always_ff @(posedge clk_rtl or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (accept) state_d = last_beat ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          if (last_beat) state_d = S_DONE;
        end else if (idle_expire) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_start) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    i_ready_out = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state_q)
      S_ARMED, S_RUN: begin
        i_ready_out = ~i_stall;
        o_busy      = 1'b1;
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  // Payload checking and beat counters
  always_ff @(posedge clk_rtl or negedge rst) begin
    if (!rst) begin
      lfsr_q       <= SEED;
      num_rx_q     <= '0;
      num_fail_q   <= '0;
      first_fail_q <= '1;
    end else if (start_arm) begin
      lfsr_q       <= SEED;
      num_rx_q     <= '0;
      num_fail_q   <= '0;
      first_fail_q <= '1;
    end else if (accept) begin
      lfsr_q   <= lfsr_next;
      num_rx_q <= sat_inc(num_rx_q);
      if (mismatch) begin
        num_fail_q <= sat_inc(num_fail_q);
        if (first_fail_q == '1) first_fail_q <= num_rx_q;
      end
    end
  end

  // Timing counters: latency runs in ARMED, span and idle run in RUN.
  // Stalls do not pause them, so backpressure shows up in the results.
  always_ff @(posedge clk_rtl or negedge rst) begin
    if (!rst) begin
      latency_q <= '0;
      span_q    <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else if (start_arm) begin
      latency_q <= '0;
      span_q    <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_ARMED: begin
          latency_q <= sat_inc(latency_q);
          if (accept) begin
            span_q <= CNT_W'(1);
            idle_q <= '0;
          end
        end
        S_RUN: begin
          span_q <= sat_inc(span_q);
          if (accept) begin
            idle_q <= '0;
          end else begin
            idle_q <= sat_inc(idle_q);
            if (idle_expire) timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_timeout    = timeout_q;
  assign o_pass       = (state_q == S_DONE) & ~timeout_q & (num_fail_q == '0);
  assign o_num_rx     = num_rx_q;
  assign o_num_fail   = num_fail_q;
  assign o_first_fail = first_fail_q;
  assign o_latency    = latency_q;
  assign o_span       = span_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_traffic_checker.sv
// Directed bench for traffic_checker: clean, corrupted, stalled, timeout,
// mid-run reset and ignored-start runs with hand-derived expected results.
module tb_traffic_checker;

  localparam int          WD   = 400;
  localparam int          NE   = 100;
  localparam int          TO   = 4096;
  localparam int          CW   = 32;
  localparam logic [31:0] SEED = 32'hBAADF00D;
  localparam logic [31:0] POLY = 32'hA3000000;
  localparam logic [63:0] ONES = 64'h0000_0000_FFFF_FFFF;

  logic          clk_rtl;
  logic          rst;
  logic [WD-1:0] i_data_in;
  logic          i_valid_in;
  logic          i_ready_out;
  logic          i_start;
  logic          i_stall;
  logic          o_busy, o_done, o_pass, o_timeout;
  logic [CW-1:0] o_num_rx, o_num_fail, o_first_fail, o_latency, o_span;
  logic [1:0]    o_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus model state
  logic [WD-1:0] exp_q[$];
  logic [31:0]   lfsr_m;
  int            sent;
  int            bad_a;
  int            bad_b;
  int            stall_en;

  traffic_checker #(
    .WIDTH_DATA(WD), .N_EXPECT(NE), .SEED(SEED), .POLY(POLY),
    .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk_rtl(clk_rtl), .rst(rst),
    .i_data_in(i_data_in), .i_valid_in(i_valid_in), .i_ready_out(i_ready_out),
    .i_start(i_start), .i_stall(i_stall),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_num_rx(o_num_rx), .o_num_fail(o_num_fail), .o_first_fail(o_first_fail),
    .o_latency(o_latency), .o_span(o_span), .o_state(o_state)
  );

  // Clock
  initial clk_rtl = 1'b0;
  always #5 clk_rtl = ~clk_rtl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WD-1:0] beat_of(input logic [31:0] s);
    logic [WD-1:0] r;
    for (int i = 0; i < WD; i++) r[i] = s[i % 32];
    return r;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Queue the next payload from the model (beat index = queue order).
  task automatic push_next();
    exp_q.push_back(beat_of(lfsr_m));
    lfsr_m = lfsr_step(lfsr_m);
  endtask

  task automatic tick();
    @(posedge clk_rtl);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; i_valid_in = 1'b0; i_start = 1'b0; i_stall = 1'b0; i_data_in = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic start_run(input string tag);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    lfsr_m = SEED;
    sent = 0;
    exp_q.delete();
    check({tag, "_ready"}, i_ready_out, 1);
    check({tag, "_busy"}, o_busy, 1);
    check({tag, "_clr_rx"}, o_num_rx, 0);
    check({tag, "_clr_ff"}, o_first_fail, ONES);
  endtask

  // Send n beats in order, holding valid; stall 3 cycles after every 10th accept.
  task automatic send_beats(input int n, input string tag);
    int goal = sent + n;
    int stall_left = 0;
    int cyc = 0;
    int rdy_err = 0;
    logic acc;
    logic [WD-1:0] d;
    while (sent < goal && cyc < 2000) begin
      if (exp_q.size() == 0) push_next();
      d = exp_q[0];
      if (sent == bad_a) d[0] = ~d[0];
      if (sent == bad_b) d = ~d;
      i_data_in  = d;
      i_valid_in = 1'b1;
      i_stall    = (stall_left > 0);
      #1;
      if (i_ready_out !== ~i_stall) rdy_err++;
      acc = i_ready_out;
      tick();
      cyc++;
      if (acc) begin
        void'(exp_q.pop_front());
        sent++;
        if (stall_en != 0 && sent % 10 == 0 && sent < NE) stall_left = 3;
      end else if (stall_left > 0) begin
        stall_left--;
      end
    end
    i_valid_in = 1'b0;
    i_stall    = 1'b0;
    check({tag, "_sent"}, sent, goal);
    check({tag, "_ready_errs"}, rdy_err, 0);
  endtask

  task automatic check_done(input string tag, input int rx, input int nf, input logic [63:0] ff,
                            input logic ps, input logic to);
    check({tag, "_done"}, o_done, 1);
    check({tag, "_ready_off"}, i_ready_out, 0);
    check({tag, "_num_rx"}, o_num_rx, rx);
    check({tag, "_num_fail"}, o_num_fail, nf);
    check({tag, "_first_fail"}, o_first_fail, ff);
    check({tag, "_pass"}, o_pass, ps);
    check({tag, "_timeout"}, o_timeout, to);
  endtask

  initial begin
    int cyc;
    int rdy_err;
    bad_a = -1; bad_b = -1; stall_en = 0;
    do_reset();

    // Reset values
    check("rst_state", o_state, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_pass", o_pass, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_ready", i_ready_out, 0);
    check("rst_num_rx", o_num_rx, 0);
    check("rst_num_fail", o_num_fail, 0);
    check("rst_first_fail", o_first_fail, ONES);
    check("rst_latency", o_latency, 0);
    check("rst_span", o_span, 0);

    // Valid driven in IDLE must never be accepted
    rdy_err = 0;
    i_data_in = beat_of(SEED);
    i_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i_ready_out !== 1'b0) rdy_err++;
    end
    i_valid_in = 1'b0;
    check("idle_ready_errs", rdy_err, 0);
    check("idle_num_rx", o_num_rx, 0);
    check("idle_state", o_state, 0);

    // Clean back-to-back run
    start_run("clean");
    send_beats(NE, "clean");
    check_done("clean", NE, 0, ONES, 1, 0);
    check("clean_latency", o_latency, 1);
    check("clean_span", o_span, NE);
    check("clean_busy", o_busy, 0);

    // Beat 5 bit 0 flipped, beat 9 inverted
    bad_a = 5; bad_b = 9;
    start_run("corrupt");
    send_beats(NE, "corrupt");
    check_done("corrupt", NE, 2, 5, 0, 0);
    bad_a = -1; bad_b = -1;

    // Stall 3 cycles after every 10th accept
    stall_en = 1;
    start_run("stall");
    send_beats(NE, "stall");
    check_done("stall", NE, 0, ONES, 1, 0);
    check("stall_span", o_span, NE + 9 * 3);
    check("stall_latency", o_latency, 1);
    stall_en = 0;

    // Start pulsed during RUN is ignored; one idle cycle lengthens the span
    start_run("restart");
    send_beats(20, "restart_a");
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("restart_busy", o_busy, 1);
    check("restart_num_rx", o_num_rx, 20);
    check("restart_latency", o_latency, 1);
    send_beats(NE - 20, "restart_b");
    check_done("restart", NE, 0, ONES, 1, 0);
    check("restart_span", o_span, NE + 1);

    // Timeout after 50 beats
    start_run("tmo");
    send_beats(50, "tmo");
    check("tmo_running", o_done, 0);
    cyc = 0;
    while (o_done !== 1'b1 && cyc < TO + 100) begin
      tick();
      cyc++;
    end
    check("tmo_cycles", cyc, TO);
    check_done("tmo", 50, 0, ONES, 0, 1);

    // Reset mid-run at beat 40 aborts at once
    start_run("midrst");
    send_beats(40, "midrst");
    rst = 1'b0;
    #2;
    check("midrst_state", o_state, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_ready", i_ready_out, 0);
    check("midrst_num_rx", o_num_rx, 0);
    check("midrst_first_fail", o_first_fail, ONES);
    check("midrst_latency", o_latency, 0);
    check("midrst_span", o_span, 0);
    tick();
    rst = 1'b1;
    tick();
    start_run("rerun");
    send_beats(NE, "rerun");
    check_done("rerun", NE, 0, ONES, 1, 0);
    check("rerun_span", o_span, NE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/traffic_checker.md
# traffic_checker

Synthesizable receive-side traffic checker for the fabric interface. It sits on the data side of a depacketizer and consumes a ready/valid data stream. It regenerates the expected payload sequence from a seeded LFSR and counts received and mismatched beats. It also measures first-beat latency and beat span, and flags a stall timeout, so on-chip latency/throughput runs need no simulator-side checker.

## Interface
Parameters:
- WIDTH_DATA, 400, payload width of each beat.
- N_EXPECT, 100, number of beats per run.
- SEED, 32'hBAADF00D, LFSR value used for beat 0.
- POLY, 32'hA3000000, right-shift Galois LFSR mask.
- CNT_W, 32, width of all counters.
- TIMEOUT, 4096, idle cycles in RUN before abort.

Ports:
- clk_rtl, in, 1, module clock; the block uses this single clock only.
- rst, in, 1, asynchronous, active-low reset.
- i_data_in, in, WIDTH_DATA, received payload.
- i_valid_in, in, 1, payload valid.
- i_ready_out, out, 1, checker can accept a beat.
- i_start, in, 1, one-cycle pulse that arms a run.
- i_stall, in, 1, forces i_ready_out low (backpressure injection).
- o_busy, out, 1, state is ARMED or RUN.
- o_done, out, 1, state is DONE.
- o_pass, out, 1, valid while o_done: no mismatches and no timeout.
- o_timeout, out, 1, the run was aborted by timeout.
- o_num_rx, out, CNT_W, number of accepted beats.
- o_num_fail, out, CNT_W, number of mismatched beats.
- o_first_fail, out, CNT_W, index of the first mismatched beat; all-ones if none.
- o_latency, out, CNT_W, cycles from start accept to first beat.
- o_span, out, CNT_W, cycles from first beat to last beat, inclusive.

## Operation
- States: IDLE, ARMED, RUN, DONE.
- IDLE or DONE, i_start=1 → ARMED. This clears all counters, sets o_first_fail to all-ones, loads the LFSR with SEED, and clears o_timeout and o_pass.
- i_start is ignored in ARMED and RUN.
- Accept = i_valid_in & i_ready_out.
- i_ready_out = (ARMED|RUN) & !i_stall. The checker never accepts in IDLE or DONE, and never drops a beat.
- Expected beat = low WIDTH_DATA bits of the LFSR state concatenated with itself ceil(WIDTH_DATA/32) times.
- On each accept:
  - o_num_rx increments.
  - On a compare mismatch, o_num_fail increments. o_first_fail is set to the pre-increment o_num_rx if it is still all-ones.
  - The LFSR advances: next = lfsr[0] ? (lfsr>>1)^POLY : lfsr>>1.
- ARMED: the latency counter increments every cycle. The first accept freezes o_latency, sets the span counter to 1, and moves to RUN.
- RUN: the span counter increments every cycle. An accept restarts the idle counter.
- RUN → DONE when the N_EXPECT-th beat is accepted. o_span is frozen on that cycle, with the last-beat cycle counted.
- N_EXPECT=1: the first accept goes from ARMED directly to DONE with o_span=1.
- RUN → DONE with o_timeout=1 when the idle counter reaches TIMEOUT.
- ARMED has no timeout.
- o_pass = o_done & !o_timeout & (o_num_fail==0).
- All counters saturate at all-ones and never wrap.

## Timing
- All outputs are registered except i_ready_out, which is a combinational function of state and i_stall.
- Start to ready: accept i_start at edge k; i_ready_out=1 in the cycle after edge k.
- A beat accepted at edge k is reflected in o_num_rx, o_num_fail and o_first_fail after edge k.
- DONE is entered at the same edge as the final accept. o_done=1 and i_ready_out=0 from the next cycle.
- Throughput: one beat per cycle sustained.
- Reset values: state IDLE; all counters 0; o_first_fail all-ones; o_busy, o_done, o_pass, o_timeout and i_ready_out all 0.
- Reset asserted mid-run aborts immediately. No partial results are retained.
- i_stall can change on any cycle. While it is high, no accept occurs, but the latency, span and idle counters keep running.

## Test plan
- Reset, start, then 100 beats of the correct sequence, back-to-back, valid the cycle after start. Beat0=0x…BAADF00D replicated, beat1=0xFE56F806 replicated, beat2=0x7F2B7C03 replicated. Required: o_done, o_pass=1, o_num_rx=100, o_num_fail=0, o_first_fail=all-ones, o_latency=1, o_span=100.
- Same run with beat 5 having bit 0 flipped and beat 9 corrupted. Required: o_num_fail=2, o_first_fail=5, o_pass=0, o_num_rx=100.
- i_stall held high 3 cycles after every 10th accept, with valid held throughout. Required: no beat lost or duplicated, o_num_fail=0, o_span=100+9×3=127.
- Send 50 beats, then idle with valid low. Required: o_timeout=1 and o_done exactly TIMEOUT cycles after beat 50, o_num_rx=50, o_pass=0.
- Assert rst mid-run at beat 40, then release, start, and send a full run. Required: all outputs return to reset values at once, and the second run passes with o_num_rx=100.
- Pulse i_start during RUN and drive valid while in IDLE. Required: the start is ignored and counters continue; no accept happens in IDLE (i_ready_out=0).
